// File: rtl/iob_tb_uart_mux_pkg.sv
// Shared types and constants for the tester-side UART multiplexer.
// State encoding, default error word and slice-width helpers.
package iob_tb_uart_mux_pkg;

    localparam int          STATE_W      = 2;
    localparam logic [1:0]  S_IDLE       = 2'd0;
    localparam logic [1:0]  S_REQ        = 2'd1;
    localparam logic [1:0]  S_RESP       = 2'd2;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = S_IDLE,
        ST_REQ  = S_REQ,
        ST_RESP = S_RESP
    } state_t;

    // Pointer width stays at least one bit so N=1 builds cleanly.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int strb_w(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/iob_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping past N-1 back to 0. Output is one-hot, or zero with no requests.
module iob_rr_arbiter
    import iob_tb_uart_mux_pkg::*;
#(
    parameter int N     = 2,
    parameter int PTR_W = ptr_w(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o
);

    logic [N-1:0] w_req_rot;
    logic [N-1:0] w_gnt_rot;

    // Rotate so the pointer position lands at bit 0, then pick the lowest set bit.
    assign w_req_rot = N'({req_i, req_i} >> ptr_i);

    always_comb begin
        w_gnt_rot = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_gnt_rot    = '0;
                w_gnt_rot[k] = 1'b1;
            end
        end
    end

    assign grant_o = N'(({w_gnt_rot, w_gnt_rot} << ptr_i) >> N);

endmodule

// File: rtl/iob_tb_uart_mux.sv
// N-to-1 IOb multiplexer letting several tester masters share one tester UART.
// Round-robin, one transaction in flight, read timeout answers with an error word.
module iob_tb_uart_mux
    import iob_tb_uart_mux_pkg::*;
#(
    parameter int          N_MASTERS = 2,
    parameter int          ADDR_W    = 3,
    parameter int          DATA_W    = 32,
    parameter int          TIMEOUT_W = 8,
    parameter logic [31:0] ERR_DATA  = DEF_ERR_DATA
) (
    input  logic                            clk_i,
    input  logic                            arst_i,
    input  logic                            cke_i,
    input  logic [N_MASTERS-1:0]            m_avalid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata_i,
    input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb_i,
    output logic [N_MASTERS*DATA_W-1:0]     m_rdata_o,
    output logic [N_MASTERS-1:0]            m_rvalid_o,
    output logic [N_MASTERS-1:0]            m_ready_o,
    output logic                            s_avalid_o,
    output logic [ADDR_W-1:0]               s_addr_o,
    output logic [DATA_W-1:0]               s_wdata_o,
    output logic [(DATA_W/8)-1:0]           s_wstrb_o,
    input  logic [DATA_W-1:0]               s_rdata_i,
    input  logic                            s_rvalid_i,
    input  logic                            s_ready_i,
    output logic [N_MASTERS-1:0]            grant_o,
    output logic                            timeout_o
);

    localparam int STRB_W = strb_w(DATA_W);
    localparam int PTR_W  = ptr_w(N_MASTERS);

    state_t                 r_state, w_state_nxt;
    logic [N_MASTERS-1:0]   r_grant, w_grant_nxt, w_arb_grant;
    logic [PTR_W-1:0]       r_ptr, w_ptr_nxt, w_gidx, w_ptr_inc;
    logic [TIMEOUT_W-1:0]   r_cnt, w_cnt_nxt;

    logic                   w_sel_avalid;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_wdata;
    logic [STRB_W-1:0]      w_sel_wstrb;
    logic                   w_is_write;
    logic                   w_resp_hit;
    logic                   w_resp_to;
    logic [DATA_W-1:0]      w_resp_data;
    logic [N_MASTERS-1:0]   w_rvalid;

    iob_rr_arbiter #(
        .N     (N_MASTERS),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i   (m_avalid_i),
        .ptr_i   (r_ptr),
        .grant_o (w_arb_grant)
    );

    // Select the granted master's request fields; all zero while nothing is granted.
    always_comb begin
        w_sel_avalid = 1'b0;
        w_sel_addr   = '0;
        w_sel_wdata  = '0;
        w_sel_wstrb  = '0;
        w_gidx       = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (r_grant[i]) begin
                w_sel_avalid = m_avalid_i[i];
                w_sel_addr   = m_addr_i[i*ADDR_W +: ADDR_W];
                w_sel_wdata  = m_wdata_i[i*DATA_W +: DATA_W];
                w_sel_wstrb  = m_wstrb_i[i*STRB_W +: STRB_W];
                w_gidx       = PTR_W'(i);
            end
        end
    end

    assign w_ptr_inc   = (w_gidx == PTR_W'(N_MASTERS - 1)) ? '0 : w_gidx + 1'b1;
    assign w_is_write  = |w_sel_wstrb;

    assign s_avalid_o  = (r_state == ST_REQ) && w_sel_avalid;
    assign s_addr_o    = w_sel_addr;
    assign s_wdata_o   = w_sel_wdata;
    assign s_wstrb_o   = w_sel_wstrb;

    // Real data beats the timeout when both land in the same cycle.
    assign w_resp_hit  = (r_state == ST_RESP) && s_rvalid_i;
    assign w_resp_to   = (r_state == ST_RESP) && !s_rvalid_i && (&r_cnt);
    assign w_resp_data = s_rvalid_i ? s_rdata_i : DATA_W'(ERR_DATA);
    assign w_rvalid    = (w_resp_hit || w_resp_to) ? r_grant : '0;

    assign m_rvalid_o  = w_rvalid;
    assign m_ready_o   = ((r_state == ST_REQ) && s_ready_i) ? r_grant : '0;
    assign grant_o     = r_grant;
    assign timeout_o   = w_resp_to;

    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_rdata
        assign m_rdata_o[gi*DATA_W +: DATA_W] = w_rvalid[gi] ? w_resp_data : '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (|m_avalid_i) begin
                    w_grant_nxt = w_arb_grant;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // Withdrawn request or completed write both release the channel.
                if (!w_sel_avalid || (s_ready_i && w_is_write)) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_ptr_inc;
                end else if (s_ready_i) begin
                    w_state_nxt = ST_RESP;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RESP: begin
                if (w_resp_hit || w_resp_to) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_ptr_inc;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else if (cke_i) begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule
